// File: rtl/ddr3_host_requester.sv
// ddr3_host_requester
//   Host-side initiator in front of the DDR3 controller. A client request
//   (single word or 8/16/24/32-word block, read or write) becomes exactly one
//   controller command word. For writes, all data is pushed into the
//   controller data FIFO before the command goes out. For reads, return words
//   are popped one at a time and handed back to the client with their address.
//
// Ports
//   clk, resetbar            clock, asynchronous active-low reset
//   req_*                    client request channel (valid/ready)
//   wdata/wdata_valid/_ready client write-data channel (valid/ready)
//   rdata/rdata_addr/_valid  returned read words, one-cycle pulse each
//   done, err                completion pulse, sticky read-timeout flag
//   ctl_ready, ctl_notfull   controller init-complete and data-FIFO space
//   cmd, sz, op, addr        controller command word (cmd is NOP except 1 cycle)
//   din, din_put             controller data-FIFO push
//   read, dout, raddr, validout  controller return-FIFO pop and data
//   dbg_state                current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. req_ready is registered; wdata_ready is combinational from the state
// and ctl_notfull and does not depend on wdata_valid.
module ddr3_host_requester #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic        clk,
  input  logic        resetbar,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_block,
  input  logic [1:0]  req_sz,
  input  logic [25:0] req_addr,
  input  logic [15:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [15:0] rdata,
  output logic [25:0] rdata_addr,
  output logic        rdata_valid,
  output logic        done,
  output logic        err,
  input  logic        ctl_ready,
  input  logic        ctl_notfull,
  output logic [2:0]  cmd,
  output logic [1:0]  sz,
  output logic [2:0]  op,
  output logic [25:0] addr,
  output logic [15:0] din,
  output logic        din_put,
  output logic        read,
  input  logic [15:0] dout,
  input  logic [25:0] raddr,
  input  logic        validout,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WPUSH    = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_RCOLLECT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_SCR = 3'b001;
  localparam logic [2:0] CMD_SCW = 3'b010;
  localparam logic [2:0] CMD_BLR = 3'b011;
  localparam logic [2:0] CMD_BLW = 3'b100;

  logic [2:0]    state;
  logic [5:0]    cnt;
  logic [TW-1:0] timer;
  logic          outstanding;
  logic          l_write;
  logic          l_block;
  logic [1:0]    l_sz;
  logic [25:0]   l_addr;

  logic [5:0]    n_req;
  logic [5:0]    n_latched;
  logic [2:0]    cmd_code;
  logic          pend_after;
  logic          timed_out;

  // Word count: 1 for single access, 8*(sz+1) for a block.
  function automatic logic [5:0] n_words(input logic blk, input logic [1:0] s);
    logic [2:0] k;
    k = {1'b0, s} + 3'd1;
    return blk ? {k, 3'b000} : 6'd1;
  endfunction

  always_comb begin
    n_req      = n_words(req_block, req_sz);
    n_latched  = n_words(l_block, l_sz);
    cmd_code   = l_write ? (l_block ? CMD_BLW : CMD_SCW)
                         : (l_block ? CMD_BLR : CMD_SCR);
    // A pop is still in flight after this edge only if no word came back now.
    pend_after = outstanding && !validout;
    timed_out  = !validout && (timer == TW'(TIMEOUT));
  end

  assign wdata_ready = (state == S_WPUSH) && ctl_notfull;
  assign op          = 3'b000;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      state       <= S_IDLE;
      cnt         <= '0;
      timer       <= '0;
      outstanding <= 1'b0;
      l_write     <= 1'b0;
      l_block     <= 1'b0;
      l_sz        <= '0;
      l_addr      <= '0;
      req_ready   <= 1'b0;
      rdata       <= '0;
      rdata_addr  <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cmd         <= CMD_NOP;
      sz          <= '0;
      addr        <= '0;
      din         <= '0;
      din_put     <= 1'b0;
      read        <= 1'b0;
    end else begin
      // Strobes default low; each state raises what it needs for one cycle.
      cmd         <= CMD_NOP;
      din_put     <= 1'b0;
      read        <= 1'b0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            l_write   <= req_write;
            l_block   <= req_block;
            l_sz      <= req_sz;
            l_addr    <= req_addr;
            cnt       <= n_req;
            err       <= 1'b0;
            req_ready <= 1'b0;
            state     <= req_write ? S_WPUSH : S_ISSUE;
          end else begin
            req_ready <= ctl_ready;
          end
        end
        S_WPUSH: begin
          if (wdata_valid && ctl_notfull) begin
            din     <= wdata;
            din_put <= 1'b1;
            cnt     <= cnt - 6'd1;
            if (cnt == 6'd1) state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cmd  <= cmd_code;
          sz   <= l_block ? l_sz : 2'b00;
          addr <= l_addr;
          if (l_write) begin
            state <= S_DONE;
          end else begin
            cnt         <= n_latched;
            timer       <= '0;
            outstanding <= 1'b0;
            state       <= S_RCOLLECT;
          end
        end
        S_RCOLLECT: begin
          if (validout) begin
            rdata       <= dout;
            rdata_addr  <= raddr;
            rdata_valid <= 1'b1;
            cnt         <= cnt - 6'd1;
            timer       <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
          if (validout && cnt == 6'd1) begin
            outstanding <= 1'b0;
            state       <= S_DONE;
          end else if (timed_out) begin
            err         <= 1'b1;
            outstanding <= 1'b0;
            state       <= S_DONE;
          end else if (!pend_after) begin
            // Words remain and nothing is in flight: pop the next one.
            read        <= 1'b1;
            outstanding <= 1'b1;
          end else begin
            outstanding <= 1'b1;
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          req_ready <= ctl_ready;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_host_requester.sv
// Bench for ddr3_host_requester: table of directed requests, hand-written
// corner sequences (reset, timeout, stalls, mid-read reset) and randomized
// requests. A small controller model answers each read pop one cycle later.
module tb_ddr3_host_requester;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        resetbar;
  logic        req_valid, req_ready, req_write, req_block;
  logic [1:0]  req_sz;
  logic [25:0] req_addr;
  logic [15:0] wdata;
  logic        wdata_valid, wdata_ready;
  logic [15:0] rdata;
  logic [25:0] rdata_addr;
  logic        rdata_valid, done, err;
  logic        ctl_ready, ctl_notfull;
  logic [2:0]  cmd, op, dbg_state;
  logic [1:0]  sz;
  logic [25:0] addr, raddr;
  logic [15:0] din, dout;
  logic        din_put, read, validout;

  ddr3_host_requester #(.TIMEOUT(TIMEOUT), .TW(13)) dut (
    .clk(clk), .resetbar(resetbar),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_block(req_block), .req_sz(req_sz), .req_addr(req_addr),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_addr(rdata_addr), .rdata_valid(rdata_valid),
    .done(done), .err(err), .ctl_ready(ctl_ready), .ctl_notfull(ctl_notfull),
    .cmd(cmd), .sz(sz), .op(op), .addr(addr), .din(din), .din_put(din_put),
    .read(read), .dout(dout), .raddr(raddr), .validout(validout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [41:0] exp_q[$];      // {rdata_addr, rdata}
  logic [15:0] exp_din_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts strobes and checks pushed/returned words against queues.
  int din_cnt = 0, cmd_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int din_at_cmd = 0, cmd_cyc = 0, done_cyc = 0;
  logic [2:0]  last_cmd = '0, last_op = '0;
  logic [1:0]  last_sz = '0;
  logic [25:0] last_addr = '0;

  always @(negedge clk) begin
    if (resetbar === 1'b1) begin
      if (din_put) begin
        din_cnt++;
        if (exp_din_q.size() == 0) chk("din_unexpected", din_put, 0);
        else chk("din_word", din, exp_din_q.pop_front());
      end
      if (cmd != 3'b000) begin
        cmd_cnt++;
        last_cmd = cmd; last_sz = sz; last_addr = addr; last_op = op;
        cmd_cyc = cyc; din_at_cmd = din_cnt;
      end
      if (rdata_valid) begin
        rd_cnt++;
        if (exp_q.size() == 0) chk("rdata_unexpected", rdata_valid, 0);
        else chk("rdata_word", {rdata_addr, rdata}, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Controller model: each pop returns data_base+i / cur_addr+i one cycle later.
  logic        resp_en = 1'b1, inject = 1'b0;
  int          rd_total = 0, rd_snap = 0;
  logic [25:0] cur_addr = '0;
  logic [15:0] data_base = '0;
  always @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      validout <= 1'b0; dout <= '0; raddr <= '0;
    end else begin
      validout <= (read && resp_en) || inject;
      if (read) begin
        dout     <= data_base + 16'(rd_total - rd_snap);
        raddr    <= cur_addr + 26'(rd_total - rd_snap);
        rd_total <= rd_total + 1;
      end else if (inject) begin
        dout <= 16'hDEAD; raddr <= 26'h155;
      end
    end
  end

  // ---------------- reference rules ----------------
  function automatic logic [2:0] exp_cmd_f(input bit w, input bit b);
    if (w) return b ? 3'b100 : 3'b010;
    return b ? 3'b011 : 3'b001;
  endfunction
  function automatic int exp_n_f(input bit b, input logic [1:0] s);
    return b ? 8 * (int'(s) + 1) : 1;
  endfunction

  // ---------------- driver tasks ----------------
  int sn_din, sn_cmd, sn_rd, sn_done, acc_cyc;
  logic [2:0] idle_code;

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic accept_req(input bit w, input bit b, input logic [1:0] s,
                            input logic [25:0] a, input logic [15:0] base);
    int g = 0;
    while (!req_ready && g < 100) begin step(); g++; end
    chk("req_ready_wait", req_ready, 1);
    cur_addr = a; data_base = base; rd_snap = rd_total;
    sn_din = din_cnt; sn_cmd = cmd_cnt; sn_rd = rd_cnt; sn_done = done_cnt;
    req_write = w; req_block = b; req_sz = s; req_addr = a; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    acc_cyc = cyc;
    chk("req_ready_drop", req_ready, 0);
    chk("err_cleared", err, 0);
  endtask

  // mode 0: always ready; 1: ctl_notfull low for 3 cycles mid-burst; 2: random
  task automatic drive_write(input int n, input logic [15:0] base, input int mode);
    int idx = 0, it = 0;
    bit prev = 0, nf;
    while (idx < n && it < 2000) begin
      wdata = base + 16'(idx);
      case (mode)
        0: begin nf = 1; wdata_valid = 1'b1; end
        1: begin nf = !(it >= 5 && it <= 7); wdata_valid = 1'b1; end
        default: begin nf = ($urandom_range(0, 3) != 0); wdata_valid = ($urandom_range(0, 3) != 0); end
      endcase
      ctl_notfull = nf;
      #1;
      chk("wdata_ready", wdata_ready, nf);
      if (it > 0) chk("din_put_cycle", din_put, prev);
      prev = wdata_valid && nf;
      if (prev) idx++;
      it++;
      step();
    end
    chk("din_put_last", din_put, prev);
    wdata_valid = 1'b0; ctl_notfull = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    int g = 0;
    while (done_cnt == sn_done && g < limit) begin step(); g++; end
    chk("done_seen", done_cnt - sn_done, 1);
    step();
    chk("done_single", done_cnt - sn_done, 1);
    chk("idle_return", dbg_state, idle_code);
  endtask

  task automatic run_vec(input bit w, input bit b, input logic [1:0] s,
                         input logic [25:0] a, input logic [15:0] base, input int mode,
                         input logic [2:0] ecmd, input logic [1:0] esz, input int n,
                         input bit drop_rdy);
    for (int i = 0; i < n; i++) begin
      if (w) exp_din_q.push_back(base + 16'(i));
      else exp_q.push_back({a + 26'(i), base + 16'(i)});
    end
    accept_req(w, b, s, a, base);
    if (drop_rdy) ctl_ready = 1'b0;
    if (w) drive_write(n, base, mode);
    wait_done(n * 8 + 100);
    chk("cmd_count", cmd_cnt - sn_cmd, 1);
    chk("cmd_code", last_cmd, ecmd);
    chk("cmd_sz", last_sz, esz);
    chk("cmd_addr", last_addr, a);
    chk("cmd_op", last_op, 0);
    if (w) begin
      chk("din_count", din_cnt - sn_din, n);
      chk("data_before_cmd", din_at_cmd - sn_din, n);
      if (mode == 0 && !b) chk("write_done_latency", done_cyc - acc_cyc, 3);
    end else begin
      chk("rdata_count", rd_cnt - sn_rd, n);
      chk("read_cmd_latency", cmd_cyc - acc_cyc, 1);
    end
    chk("exp_q_drained", exp_q.size() + exp_din_q.size(), 0);
    chk("err_after", err, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          w;
    bit          b;
    logic [1:0]  s;
    logic [25:0] a;
    logic [15:0] base;
    int          mode;
    logic [2:0]  ecmd;
    logic [1:0]  esz;
    int          n;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'd0, 26'h0000123, 16'hBEEF, 0, 3'b010, 2'd0, 1};
    tbl[1] = '{1'b1, 1'b1, 2'd1, 26'h0000200, 16'h1000, 1, 3'b100, 2'd1, 16};
    tbl[2] = '{1'b0, 1'b1, 2'd3, 26'h0000040, 16'h0000, 0, 3'b011, 2'd3, 32};
    tbl[3] = '{1'b0, 1'b0, 2'd0, 26'h3FFFFFF, 16'h1234, 0, 3'b001, 2'd0, 1};
    tbl[4] = '{1'b1, 1'b1, 2'd3, 26'h0000000, 16'hFFF0, 0, 3'b100, 2'd3, 32};
    tbl[5] = '{1'b0, 1'b1, 2'd0, 26'h0000100, 16'h7700, 0, 3'b011, 2'd0, 8};
    tbl[6] = '{1'b1, 1'b0, 2'd2, 26'h2AAAAAA, 16'h5A5A, 0, 3'b010, 2'd0, 1};
  end

  // ---------------- test sequence ----------------
  initial begin
    resetbar = 1'b0; ctl_ready = 1'b0; ctl_notfull = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_block = 1'b0; req_sz = '0; req_addr = '0;
    wdata = '0; wdata_valid = 1'b0;
    repeat (3) step();
    resetbar = 1'b1;
    step();
    idle_code = dbg_state;
    chk("reset_outputs", {cmd, sz, op, addr, din, din_put, read, wdata_ready,
                          rdata_valid, done, err, req_ready}, 0);
    chk("reset_rdata", {rdata_addr, rdata}, 0);
    ctl_ready = 1'b1;
    chk("req_ready_registered", req_ready, 0);
    step();
    chk("req_ready_rise", req_ready, 1);

    foreach (tbl[i])
      run_vec(tbl[i].w, tbl[i].b, tbl[i].s, tbl[i].a, tbl[i].base, tbl[i].mode,
              tbl[i].ecmd, tbl[i].esz, tbl[i].n, 1'b0);

    // validout outside RCOLLECT is ignored
    sn_rd = rd_cnt;
    inject = 1'b1; step(); inject = 1'b0;
    repeat (3) step();
    chk("stray_validout", rd_cnt - sn_rd, 0);

    // ctl_ready drops mid-request: request completes, no new accept
    run_vec(1'b1, 1'b1, 2'd0, 26'h0000500, 16'h0A00, 0, 3'b100, 2'd0, 8, 1'b1);
    repeat (2) step();
    chk("no_ready_while_ctl_down", req_ready, 0);
    ctl_ready = 1'b1;
    step();
    chk("ready_after_ctl_up", req_ready, 1);

    // Read timeout
    resp_en = 1'b0;
    accept_req(1'b0, 1'b0, 2'd0, 26'h0000777, 16'h0);
    wait_done(TIMEOUT + 100);
    chk("timeout_err", err, 1);
    chk("timeout_window", ((done_cyc - acc_cyc) >= TIMEOUT) && ((done_cyc - acc_cyc) <= TIMEOUT + 4), 1);
    chk("timeout_no_rdata", rd_cnt - sn_rd, 0);
    resp_en = 1'b1;
    repeat (3) step();
    chk("err_sticky", err, 1);
    run_vec(1'b1, 1'b0, 2'd0, 26'h0000888, 16'hC0DE, 0, 3'b010, 2'd0, 1, 1'b0);

    // Reset mid-read after 5 of 8 words
    for (int i = 0; i < 8; i++) exp_q.push_back({26'h0000300 + 26'(i), 16'h5000 + 16'(i)});
    accept_req(1'b0, 1'b1, 2'd0, 26'h0000300, 16'h5000);
    for (int g = 0; g < 100 && (rd_cnt - sn_rd) < 5; g++) step();
    chk("words_before_reset", rd_cnt - sn_rd, 5);
    resetbar = 1'b0;
    #1;
    chk("midreset_outputs", {cmd, sz, op, addr, din, din_put, read, wdata_ready,
                             rdata_valid, done, err, req_ready}, 0);
    chk("midreset_rdata", {rdata_addr, rdata}, 0);
    exp_q.delete();
    repeat (3) step();
    resetbar = 1'b1;
    repeat (3) step();
    chk("midreset_no_done", done_cnt - sn_done, 0);
    chk("midreset_no_more_words", rd_cnt - sn_rd, 5);
    chk("midreset_ready", req_ready, 1);

    // Randomized requests against the reference rules
    for (int r = 0; r < 12; r++) begin
      bit w, b;
      logic [1:0] s;
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      run_vec(w, b, s, 26'($urandom), 16'($urandom), 2, exp_cmd_f(w, b),
              b ? s : 2'b00, exp_n_f(b, s), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_host_requester.md
Name: ddr3_host_requester

Overview:
- Host-side initiator for the DDR3 controller front end; it sits between a local client and the controller's cmd/din/read/dout port set.
- Takes single or block read/write requests from the client and streams write words into the controller data FIFO.
- Issues exactly one command word per request, then pops return data via read/validout and hands words plus addresses back to the client.
- Controller-side ports connect one-to-one to the controller's cmd, sz, op, addr, din, read, dout, raddr, validout, notfull and ready.

Parameters:
- TIMEOUT, 4096: cycles a read may wait for validout before aborting with err.
- TW, 13: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk in 1: single clock, also drives the controller.
- resetbar in 1: asynchronous active-low reset.
- req_valid in 1: client request strobe.
- req_ready out 1: block idle and controller ready; request accepted when req_valid && req_ready.
- req_write in 1: 1 = write, 0 = read.
- req_block in 1: 1 = block access, 0 = single word.
- req_sz in 2: block size, words = 8*(req_sz+1); ignored for single access.
- req_addr in 26: start word address.
- wdata in 16: client write word.
- wdata_valid in 1: write word present.
- wdata_ready out 1: write word consumed this cycle.
- rdata out 16: returned read word.
- rdata_addr out 26: address of rdata.
- rdata_valid out 1: one-cycle pulse per returned word.
- done out 1: one-cycle pulse when a request completes.
- err out 1: sticky read-timeout flag, cleared by the next accepted request.
- ctl_ready in 1: controller init-complete (ready).
- ctl_notfull in 1: controller data FIFO not full.
- cmd out 3: command code. 000 NOP, 001 SCR, 010 SCW, 011 BLR, 100 BLW.
- sz out 2: block size to controller.
- op out 3: always 000.
- addr out 26: command address.
- din out 16: write word to controller data FIFO.
- din_put out 1: data FIFO push.
- read out 1: return FIFO pop.
- dout in 16: return data.
- raddr in 26: return address.
- validout in 1: dout/raddr valid, one cycle after read.

Behaviour:
- Reset (async, resetbar=0): state IDLE. cmd=000, sz=00, op=000, addr=0, din=0. din_put, read, wdata_ready, rdata_valid, done, err = 0. rdata=0, rdata_addr=0, all counters 0.
- Registered outputs, with one exception: wdata_ready = (state==WPUSH) && ctl_notfull, combinational.
- cmd stays 000 in every cycle except the ISSUE cycle.
- Word count N: 1 if req_block=0, else 8*(req_sz+1), giving 8/16/24/32. Count register is 6 bits.
- IDLE:
  - req_ready = ctl_ready.
  - On accept: latch write, block, sz, addr. Load cnt=N. Clear err.
  - Go to WPUSH if write, else ISSUE.
- WPUSH:
  - Each cycle with wdata_valid && ctl_notfull: din<=wdata, din_put<=1, cnt<=cnt-1.
  - If ctl_notfull=0 or wdata_valid=0: din_put<=0, cnt holds.
  - After the push that takes cnt to 0, go to ISSUE. All write data is in the FIFO before the command.
- ISSUE (exactly 1 cycle):
  - cmd = SCW/BLW/SCR/BLR per latched write/block; sz = latched sz (00 for single); addr = latched addr.
  - Write: go to DONE.
  - Read: reload cnt=N, clear timer, go to RCOLLECT.
- RCOLLECT:
  - read<=1 while cnt-outstanding>0, where outstanding is at most 1. The pop pattern is read one cycle, wait validout, read again.
  - On validout: rdata<=dout, rdata_addr<=raddr, rdata_valid<=1 next cycle, cnt<=cnt-1, timer<=0.
  - When cnt reaches 0, go to DONE.
  - Timer increments every cycle without validout. When timer==TIMEOUT: err<=1, read<=0, go to DONE.
- DONE (1 cycle): done<=1, then IDLE.
- ctl_ready falling outside IDLE: the current request finishes; no new accept until ctl_ready=1.
- validout arriving in any state other than RCOLLECT is ignored. No rdata_valid is produced for it.
- resetbar asserted mid-operation: immediate return to reset values. Partial bursts are abandoned and no done is produced.
- Latency:
  - Single write: done 3 cycles after accept, given wdata_valid and ctl_notfull at accept+1.
  - Read: cmd visible 1 cycle after accept.

Test Plan:
- Reset/init: resetbar=0 then 1 with ctl_ready=0 -> req_ready=0, cmd=000, all strobes 0. Raise ctl_ready -> req_ready=1 next cycle.
- Single write: addr=0x0000123, wdata=0xBEEF -> one din_put with din=0xBEEF, then one cycle cmd=010 addr=0x0000123 sz=00, then done pulse.
- Block write: sz=01, ctl_notfull low for 3 cycles mid-burst -> exactly 16 din_put pulses, cnt holds during stall, then cmd=100 sz=01, then done.
- Block read: sz=11, addr=0x0000040, model returns dout=i, raddr=0x40+i -> cmd=011 sz=11, 32 rdata_valid pulses in order, done, err=0.
- Timeout: single read, model never asserts validout -> err=1 after TIMEOUT cycles, done pulse, return to IDLE. The next accepted request clears err.
- Reset mid-read: resetbar low after 5 of 8 words -> all outputs at reset values immediately, and no done pulse.
